// File: rtl/mem_arb_pkg.sv
// Shared types and encodings for the two-cache memory port arbiter.
// Used by mem_arb_pick and mem_port_arbiter.
package mem_arb_pkg;

    localparam logic [1:0] RW_IDLE  = 2'b00;
    localparam logic [1:0] RW_READ  = 2'b01;
    localparam logic [1:0] RW_WRITE = 2'b10;

    localparam logic PORT_D = 1'b0;
    localparam logic PORT_I = 1'b1;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_ISSUE = 1'b1
    } arb_state_t;

    // The cache never legitimately sends 2'b11; treat it as a write so memory sees one operation.
    function automatic logic [1:0] norm_flag(input logic [1:0] flag);
        return flag[1] ? RW_WRITE : flag;
    endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner selection between dcache (port 0) and icache (port 1).
// Define MEM_ARB_ROUND_ROBIN_EN to alternate on contention; default is fixed dcache priority.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic [1:0] active,
    input  logic       last_grant,
    output logic       grant_valid,
    output logic       grant_idx
);

`ifdef MEM_ARB_ROUND_ROBIN_EN
    always_comb begin
        grant_valid = |active;
        grant_idx   = PORT_D;
        if (&active) begin
            grant_idx = ~last_grant;
        end else if (active[1]) begin
            grant_idx = PORT_I;
        end
    end
`else
    logic last_grant_unused;
    assign last_grant_unused = last_grant;

    always_comb begin
        grant_valid = |active;
        grant_idx   = PORT_D;
        if (!active[0] && active[1]) begin
            grant_idx = PORT_I;
        end
    end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between dcache (port 0) and icache (port 1), one whole transaction at a time.
// Arbitration mode follows MEM_ARB_ROUND_ROBIN_EN (see mem_arb_pick).
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int MASK_W = DATA_W / 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [3:0]            req_rw_flag_i,
    input  logic [2*ADDR_W-1:0]   req_addr_i,
    input  logic [2*DATA_W-1:0]   req_w_data_i,
    input  logic [2*MASK_W-1:0]   req_w_mask_i,
    output logic [2*DATA_W-1:0]   req_r_data_o,
    output logic [1:0]            req_busy_o,
    output logic [1:0]            req_done_o,
    output logic [1:0]            mem_rw_flag_o,
    output logic [ADDR_W-1:0]     mem_addr_o,
    output logic [DATA_W-1:0]     mem_w_data_o,
    output logic [MASK_W-1:0]     mem_w_mask_o,
    input  logic [DATA_W-1:0]     mem_r_data_i,
    input  logic                  mem_busy_i,
    input  logic                  mem_done_i,
    output logic                  dbg_state
);

    // Requester protocol: a non-zero rw_flag is the request (valid); flag, addr, data and mask
    // stay stable until the one-cycle req_done_o pulse (ready+response), after which the
    // requester drops or replaces the request on the following edge.

    arb_state_t state;
    logic       grant;
    logic       last_grant;

    logic [1:0]        active;
    logic              grant_valid;
    logic              grant_idx;
    logic              done_now;
    logic [1:0]        sel_flag;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;
    logic [MASK_W-1:0] sel_mask;

    assign active = {|req_rw_flag_i[3:2], |req_rw_flag_i[1:0]};

    mem_arb_pick u_pick (
        .active      (active),
        .last_grant  (last_grant),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    always_comb begin
        sel_flag = req_rw_flag_i[1:0];
        sel_addr = req_addr_i[ADDR_W-1:0];
        sel_data = req_w_data_i[DATA_W-1:0];
        sel_mask = req_w_mask_i[MASK_W-1:0];
        if (grant_idx == PORT_I) begin
            sel_flag = req_rw_flag_i[3:2];
            sel_addr = req_addr_i[2*ADDR_W-1:ADDR_W];
            sel_data = req_w_data_i[2*DATA_W-1:DATA_W];
            sel_mask = req_w_mask_i[2*MASK_W-1:MASK_W];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ARB_IDLE;
            grant         <= PORT_D;
            last_grant    <= PORT_I;
            mem_rw_flag_o <= RW_IDLE;
            mem_addr_o    <= '0;
            mem_w_data_o  <= '0;
            mem_w_mask_o  <= '0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (!mem_busy_i && grant_valid) begin
                        grant         <= grant_idx;
                        mem_rw_flag_o <= norm_flag(sel_flag);
                        mem_addr_o    <= sel_addr;
                        mem_w_data_o  <= sel_data;
                        mem_w_mask_o  <= sel_mask;
                        state         <= ARB_ISSUE;
                    end else begin
                        mem_rw_flag_o <= RW_IDLE;
                    end
                end
                ARB_ISSUE: begin
                    // Downstream fields stay latched; requester changes are ignored here.
                    if (mem_done_i) begin
                        mem_rw_flag_o <= RW_IDLE;
                        last_grant    <= grant;
                        state         <= ARB_IDLE;
                    end
                end
                default: begin
                    state <= ARB_IDLE;
                end
            endcase
        end
    end

    // A reset edge abandons the transaction, so no completion may be reported in that cycle.
    assign done_now     = (state == ARB_ISSUE) && mem_done_i && !rst;
    assign req_done_o   = done_now ? ((grant == PORT_I) ? 2'b10 : 2'b01) : 2'b00;
    assign req_busy_o   = rst ? 2'b00 : (active & ~req_done_o);
    assign req_r_data_o = {2{mem_r_data_i}};
    assign dbg_state    = state;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus a downstream-issue scoreboard.
// Expected grant order follows MEM_ARB_ROUND_ROBIN_EN when the bench is built with it.
module tb_mem_port_arbiter;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int MASK_W = 4;
    localparam int TW     = 2 + ADDR_W + DATA_W + MASK_W;

    logic                clk = 1'b0;
    logic                rst;
    logic [3:0]          req_rw_flag_i;
    logic [2*ADDR_W-1:0] req_addr_i;
    logic [2*DATA_W-1:0] req_w_data_i;
    logic [2*MASK_W-1:0] req_w_mask_i;
    logic [2*DATA_W-1:0] req_r_data_o;
    logic [1:0]          req_busy_o;
    logic [1:0]          req_done_o;
    logic [1:0]          mem_rw_flag_o;
    logic [ADDR_W-1:0]   mem_addr_o;
    logic [DATA_W-1:0]   mem_w_data_o;
    logic [MASK_W-1:0]   mem_w_mask_o;
    logic [DATA_W-1:0]   mem_r_data_i;
    logic                mem_busy_i;
    logic                mem_done_i;
    logic                dbg_state;

    int errors = 0;
    int checks = 0;
    int done_cnt0 = 0;
    int done_cnt1 = 0;
    logic [TW-1:0] exp_q[$];
    logic [TW-1:0] exp_txn;
    logic [TW-1:0] obs_txn;
    logic [1:0]    prev_flag = 2'b00;
    logic          model_lg;

    mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MASK_W(MASK_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .req_rw_flag_i (req_rw_flag_i),
        .req_addr_i    (req_addr_i),
        .req_w_data_i  (req_w_data_i),
        .req_w_mask_i  (req_w_mask_i),
        .req_r_data_o  (req_r_data_o),
        .req_busy_o    (req_busy_o),
        .req_done_o    (req_done_o),
        .mem_rw_flag_o (mem_rw_flag_o),
        .mem_addr_o    (mem_addr_o),
        .mem_w_data_o  (mem_w_data_o),
        .mem_w_mask_o  (mem_w_mask_o),
        .mem_r_data_i  (mem_r_data_i),
        .mem_busy_i    (mem_busy_i),
        .mem_done_i    (mem_done_i),
        .dbg_state     (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard: every new downstream issue is popped and compared ----------------
    always @(negedge clk) begin
        if (req_done_o[0]) done_cnt0++;
        if (req_done_o[1]) done_cnt1++;
        if (prev_flag == 2'b00 && mem_rw_flag_o != 2'b00) begin
            obs_txn = {mem_rw_flag_o, mem_addr_o, mem_w_data_o, mem_w_mask_o};
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected_issue got=%h required=none", obs_txn);
            end else begin
                exp_txn = exp_q.pop_front();
                if (obs_txn !== exp_txn) begin
                    errors++;
                    $display("FAIL sb_issue got=%h required=%h", obs_txn, exp_txn);
                end
            end
        end
        prev_flag = mem_rw_flag_o;
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_port(input int p, input logic [1:0] f, input logic [31:0] a,
                              input logic [31:0] d, input logic [3:0] m);
        req_rw_flag_i[2*p +: 2]           = f;
        req_addr_i[ADDR_W*p +: ADDR_W]    = a;
        req_w_data_i[DATA_W*p +: DATA_W]  = d;
        req_w_mask_i[MASK_W*p +: MASK_W]  = m;
    endtask

    task automatic wait_issue(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (mem_rw_flag_o != 2'b00) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        req_rw_flag_i = '0; req_addr_i = '0; req_w_data_i = '0; req_w_mask_i = '0;
        mem_r_data_i = '0; mem_busy_i = 1'b0; mem_done_i = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        checks++; if (mem_rw_flag_o !== 2'b00) begin errors++; $display("FAIL rst_flag got=%b required=00", mem_rw_flag_o); end
        checks++; if (mem_addr_o !== '0) begin errors++; $display("FAIL rst_addr got=%h required=0", mem_addr_o); end
        checks++; if (mem_w_data_o !== '0) begin errors++; $display("FAIL rst_wdata got=%h required=0", mem_w_data_o); end
        checks++; if (mem_w_mask_o !== '0) begin errors++; $display("FAIL rst_mask got=%b required=0", mem_w_mask_o); end
        checks++; if (req_busy_o !== 2'b00) begin errors++; $display("FAIL rst_busy got=%b required=00", req_busy_o); end
        checks++; if (req_done_o !== 2'b00) begin errors++; $display("FAIL rst_done got=%b required=00", req_done_o); end
        checks++; if (dbg_state !== 1'b0) begin errors++; $display("FAIL rst_state got=%b required=0", dbg_state); end
        tick();
        rst = 1'b0;
        model_lg = 1'b1;
    endtask

    task automatic test_dcache_read();
        tick();
        drive_port(0, 2'b01, 32'h100, 32'h0, 4'h0);
        exp_q.push_back({2'b01, 32'h100, 32'h0, 4'h0});
        @(negedge clk);
        checks++; if (mem_rw_flag_o !== 2'b00) begin errors++; $display("FAIL rd_latency got=%b required=00", mem_rw_flag_o); end
        checks++; if (req_busy_o !== 2'b01) begin errors++; $display("FAIL rd_busy got=%b required=01", req_busy_o); end
        tick(); @(negedge clk);
        checks++; if (mem_rw_flag_o !== 2'b01 || mem_addr_o !== 32'h100) begin errors++; $display("FAIL rd_issue got=%b/%h required=01/100", mem_rw_flag_o, mem_addr_o); end
        tick(); @(negedge clk);
        checks++; if (mem_rw_flag_o !== 2'b01) begin errors++; $display("FAIL rd_hold got=%b required=01", mem_rw_flag_o); end
        tick();
        mem_done_i = 1'b1; mem_r_data_i = 32'hDEADBEEF;
        @(negedge clk);
        checks++; if (req_done_o !== 2'b01) begin errors++; $display("FAIL rd_done got=%b required=01", req_done_o); end
        checks++; if (req_r_data_o[31:0] !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_data got=%h required=deadbeef", req_r_data_o[31:0]); end
        checks++; if (req_busy_o !== 2'b00) begin errors++; $display("FAIL rd_busy_done got=%b required=00", req_busy_o); end
        tick();
        mem_done_i = 1'b0;
        drive_port(0, 2'b00, 32'h0, 32'h0, 4'h0);
        model_lg = 1'b0;
        @(negedge clk);
        checks++; if (req_done_o !== 2'b00 || mem_rw_flag_o !== 2'b00) begin errors++; $display("FAIL rd_release got=%b/%b required=00/00", req_done_o, mem_rw_flag_o); end
    endtask

    task automatic test_icache_write();
        bit ok;
        tick();
        drive_port(1, 2'b10, 32'h20, 32'h12345678, 4'b0011);
        exp_q.push_back({2'b10, 32'h20, 32'h12345678, 4'b0011});
        wait_issue(ok);
        checks++; if (!ok) begin errors++; $display("FAIL wr_issue_timeout got=none required=issue"); end
        checks++; if (mem_w_mask_o !== 4'b0011 || mem_w_data_o !== 32'h12345678) begin errors++; $display("FAIL wr_fields got=%h/%b required=12345678/0011", mem_w_data_o, mem_w_mask_o); end
        tick();
        mem_done_i = 1'b1;
        @(negedge clk);
        checks++; if (req_done_o !== 2'b10) begin errors++; $display("FAIL wr_done got=%b required=10", req_done_o); end
        tick();
        mem_done_i = 1'b0;
        drive_port(1, 2'b00, 32'h0, 32'h0, 4'h0);
        model_lg = 1'b1;
        @(negedge clk);
        checks++; if (req_done_o !== 2'b00) begin errors++; $display("FAIL wr_done_pulse got=%b required=00", req_done_o); end
    endtask

    task automatic test_illegal_flag();
        bit ok;
        tick();
        drive_port(1, 2'b11, 32'h40, 32'hA5A5A5A5, 4'b1100);
        exp_q.push_back({2'b10, 32'h40, 32'hA5A5A5A5, 4'b1100});
        wait_issue(ok);
        checks++; if (!ok || mem_rw_flag_o !== 2'b10) begin errors++; $display("FAIL illegal_flag got=%b required=10", mem_rw_flag_o); end
        tick();
        mem_done_i = 1'b1;
        tick();
        mem_done_i = 1'b0;
        drive_port(1, 2'b00, 32'h0, 32'h0, 4'h0);
        model_lg = 1'b1;
    endtask

    task automatic test_back_to_back();
        int c0, c1;
        tick();
        c0 = done_cnt0; c1 = done_cnt1;
        drive_port(0, 2'b01, 32'h200, 32'h0, 4'h0);
        drive_port(1, 2'b01, 32'h300, 32'h0, 4'h0);
        // Icache was granted last, so dcache goes first under either arbitration mode.
        exp_q.push_back({2'b01, 32'h200, 32'h0, 4'h0});
        exp_q.push_back({2'b01, 32'h300, 32'h0, 4'h0});
        tick(); @(negedge clk);
        checks++; if (mem_addr_o !== 32'h200) begin errors++; $display("FAIL b2b_first got=%h required=200", mem_addr_o); end
        tick();
        mem_done_i = 1'b1; mem_r_data_i = 32'h11112222;
        @(negedge clk);
        checks++; if (req_done_o !== 2'b01 || req_busy_o !== 2'b10) begin errors++; $display("FAIL b2b_done0 got=%b/%b required=01/10", req_done_o, req_busy_o); end
        tick();
        mem_done_i = 1'b0;
        drive_port(0, 2'b00, 32'h0, 32'h0, 4'h0);
        @(negedge clk);
        checks++; if (mem_rw_flag_o !== 2'b00 || req_busy_o !== 2'b10) begin errors++; $display("FAIL b2b_gap got=%b/%b required=00/10", mem_rw_flag_o, req_busy_o); end
        tick(); @(negedge clk);
        checks++; if (mem_rw_flag_o !== 2'b01 || mem_addr_o !== 32'h300) begin errors++; $display("FAIL b2b_second got=%b/%h required=01/300", mem_rw_flag_o, mem_addr_o); end
        tick();
        mem_done_i = 1'b1; mem_r_data_i = 32'h0BADF00D;
        @(negedge clk);
        checks++; if (req_done_o !== 2'b10 || req_r_data_o[63:32] !== 32'h0BADF00D) begin errors++; $display("FAIL b2b_done1 got=%b/%h required=10/0badf00d", req_done_o, req_r_data_o[63:32]); end
        tick();
        mem_done_i = 1'b0;
        drive_port(1, 2'b00, 32'h0, 32'h0, 4'h0);
        model_lg = 1'b1;
        @(negedge clk);
        checks++; if (done_cnt0 - c0 != 1 || done_cnt1 - c1 != 1) begin errors++; $display("FAIL b2b_pulse_count got=%0d/%0d required=1/1", done_cnt0 - c0, done_cnt1 - c1); end
    endtask

    task automatic test_mem_busy();
        tick();
        mem_busy_i = 1'b1;
        drive_port(0, 2'b10, 32'h400, 32'hCAFEF00D, 4'hF);
        exp_q.push_back({2'b10, 32'h400, 32'hCAFEF00D, 4'hF});
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++; if (mem_rw_flag_o !== 2'b00) begin errors++; $display("FAIL busy_hold_%0d got=%b required=00", i, mem_rw_flag_o); end
            tick();
        end
        mem_busy_i = 1'b0;
        @(negedge clk);
        checks++; if (mem_rw_flag_o !== 2'b00) begin errors++; $display("FAIL busy_fall got=%b required=00", mem_rw_flag_o); end
        tick(); @(negedge clk);
        checks++; if (mem_rw_flag_o !== 2'b10) begin errors++; $display("FAIL busy_issue got=%b required=10", mem_rw_flag_o); end
        tick();
        mem_busy_i = 1'b1;
        @(negedge clk);
        checks++; if (mem_rw_flag_o !== 2'b10) begin errors++; $display("FAIL busy_in_issue got=%b required=10", mem_rw_flag_o); end
        tick();
        mem_busy_i = 1'b0; mem_done_i = 1'b1;
        @(negedge clk);
        checks++; if (req_done_o !== 2'b01) begin errors++; $display("FAIL busy_done got=%b required=01", req_done_o); end
        tick();
        mem_done_i = 1'b0;
        drive_port(0, 2'b00, 32'h0, 32'h0, 4'h0);
        model_lg = 1'b0;
    endtask

    task automatic test_reset_mid();
        bit ok;
        tick();
        drive_port(0, 2'b01, 32'h500, 32'h0, 4'h0);
        exp_q.push_back({2'b01, 32'h500, 32'h0, 4'h0});
        wait_issue(ok);
        checks++; if (!ok) begin errors++; $display("FAIL rmid_issue_timeout got=none required=issue"); end
        tick();
        rst = 1'b1;
        @(negedge clk);
        checks++; if (req_done_o !== 2'b00) begin errors++; $display("FAIL rmid_done_in_rst got=%b required=00", req_done_o); end
        tick();
        rst = 1'b0;
        drive_port(0, 2'b00, 32'h0, 32'h0, 4'h0);
        model_lg = 1'b1;
        @(negedge clk);
        checks++; if ({mem_rw_flag_o, mem_addr_o, mem_w_data_o, mem_w_mask_o} !== '0) begin errors++; $display("FAIL rmid_outputs got=%b/%h required=0/0", mem_rw_flag_o, mem_addr_o); end
        checks++; if (req_busy_o !== 2'b00) begin errors++; $display("FAIL rmid_busy got=%b required=00", req_busy_o); end
        tick();
        mem_done_i = 1'b1;
        @(negedge clk);
        checks++; if (req_done_o !== 2'b00 || mem_rw_flag_o !== 2'b00) begin errors++; $display("FAIL rmid_late_done got=%b/%b required=00/00", req_done_o, mem_rw_flag_o); end
        tick();
        mem_done_i = 1'b0;
    endtask

    task automatic test_round_robin();
        bit ok;
        logic port;
        tick();
        drive_port(0, 2'b01, 32'h600, 32'h0, 4'h0);
        drive_port(1, 2'b01, 32'h700, 32'h0, 4'h0);
        for (int k = 0; k < 4; k++) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
            port = ~model_lg;
`else
            port = 1'b0;
`endif
            model_lg = port;
            exp_q.push_back({2'b01, (port ? 32'h700 : 32'h600), 32'h0, 4'h0});
            wait_issue(ok);
            checks++; if (!ok) begin errors++; $display("FAIL rr_issue_timeout_%0d got=none required=issue", k); end
            tick();
            mem_done_i = 1'b1;
            @(negedge clk);
            checks++; if (req_done_o !== (port ? 2'b10 : 2'b01)) begin errors++; $display("FAIL rr_grant_%0d got=%b required=%b", k, req_done_o, (port ? 2'b10 : 2'b01)); end
            tick();
            mem_done_i = 1'b0;
            if (k == 3) begin
                drive_port(0, 2'b00, 32'h0, 32'h0, 4'h0);
                drive_port(1, 2'b00, 32'h0, 32'h0, 4'h0);
            end
        end
        repeat (3) tick();
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_dcache_read();
        test_icache_write();
        test_illegal_flag();
        test_back_to_back();
        test_mem_busy();
        test_reset_mid();
        test_round_robin();
        @(negedge clk);
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL sb_leftover got=%0d required=0", exp_q.size()); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
